// File: rtl/ecg_class_argmax.sv
// Serial argmax over N_CLS unsigned 32-bit class scores, one compare per cycle.
// A new strobe may be accepted on the final compare cycle, so there are no dead cycles between results.
module ecg_class_argmax #(
  parameter int N_CLS = 4,
  parameter int IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [32*N_CLS-1:0]   in_scores,
  output logic                  busy,
  output logic                  out_valid,
  output logic [IDX_W-1:0]      class_idx,
  output logic [31:0]           class_score,
  output logic                  drop
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                   state;
  logic [N_CLS-1:0][31:0]   scores;
  logic [IDX_W-1:0]         ptr;
  logic [IDX_W-1:0]         best_idx;
  logic [31:0]              best_val;

  logic             last;
  logic             gt;
  logic             load;
  logic [IDX_W-1:0] nxt_idx;
  logic [31:0]      nxt_val;

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    last    = (state == SCAN) && (ptr == IDX_W'(N_CLS-1));
    gt      = scores[ptr] > best_val;
    nxt_idx = gt ? ptr : best_idx;
    nxt_val = gt ? scores[ptr] : best_val;
    load    = in_valid && ((state == IDLE) || last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      scores      <= '0;
      ptr         <= '0;
      best_idx    <= '0;
      best_val    <= '0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      drop        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == SCAN) begin
        best_idx <= nxt_idx;
        best_val <= nxt_val;
        ptr      <= ptr + IDX_W'(1);
        if (in_valid && !last)
          drop <= 1'b1;
        if (last) begin
          class_idx   <= nxt_idx;
          class_score <= nxt_val;
          out_valid   <= 1'b1;
          state       <= IDLE;
          busy        <= 1'b0;
          ptr         <= '0;
        end
      end
      // Accepting overrides the scan bookkeeping above, including on the final compare.
      if (load) begin
        scores   <= in_scores;
        best_val <= in_scores[31:0];
        best_idx <= '0;
        ptr      <= IDX_W'(1);
        state    <= SCAN;
        busy     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ecg_class_argmax.sv
// Directed and randomized checks of ecg_class_argmax against a max-then-first-index model.
module tb_ecg_class_argmax;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [127:0]  in_scores;
  logic          busy;
  logic          out_valid;
  logic [1:0]    class_idx;
  logic [31:0]   class_score;
  logic          drop;

  int checks = 0;
  int errors = 0;

  ecg_class_argmax #(.N_CLS(N), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_scores(in_scores),
    .busy(busy), .out_valid(out_valid), .class_idx(class_idx),
    .class_score(class_score), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Reference: find the maximum value, then the first class holding it.
  task automatic ref_model(input logic [127:0] sc, output logic [31:0] idx, output logic [31:0] val);
    logic [31:0] s[N];
    logic [31:0] mx;
    for (int i = 0; i < N; i++) s[i] = sc[32*i +: 32];
    mx = s[0];
    foreach (s[i]) if (s[i] > mx) mx = s[i];
    idx = 0;
    for (int i = N-1; i >= 0; i--) if (s[i] == mx) idx = i;
    val = mx;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe is sampled at the next edge; inputs scrambled afterwards.
  task automatic strobe(input logic [127:0] sc);
    in_scores = sc;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    in_scores = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic scan_check(input string tag, input logic [127:0] sc);
    logic [31:0] ei, ev;
    ref_model(sc, ei, ev);
    strobe(sc);
    chk({tag, ".busy0"}, 32'(busy), 1);
    chk({tag, ".ov0"}, 32'(out_valid), 0);
    for (int k = 1; k < N-1; k++) begin
      step();
      chk({tag, ".busy"}, 32'(busy), 1);
      chk({tag, ".ov_early"}, 32'(out_valid), 0);
    end
    step();
    chk({tag, ".busy_end"}, 32'(busy), 0);
    chk({tag, ".ov"}, 32'(out_valid), 1);
    chk({tag, ".idx"}, 32'(class_idx), ei);
    chk({tag, ".score"}, class_score, ev);
    step();
    chk({tag, ".ov_pulse"}, 32'(out_valid), 0);
    chk({tag, ".idx_hold"}, 32'(class_idx), ei);
    chk({tag, ".score_hold"}, class_score, ev);
  endtask

  initial begin
    logic [127:0] sc;
    logic [31:0]  v[N];
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_scores = '0;
    step(); step();
    reset = 1'b0;

    // Reset state and idle
    for (int i = 0; i < 5; i++) step();
    chk("rst.busy", 32'(busy), 0);
    chk("rst.ov", 32'(out_valid), 0);
    chk("rst.idx", 32'(class_idx), 0);
    chk("rst.score", class_score, 0);
    chk("rst.drop", 32'(drop), 0);

    // Reset mid-scan aborts without a result
    strobe(pack(5, 9, 1, 2));
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.ov", 32'(out_valid), 0);
    for (int i = 0; i < N; i++) begin
      step();
      chk("abort.no_ov", 32'(out_valid), 0);
    end
    chk("abort.idx", 32'(class_idx), 0);
    chk("abort.score", class_score, 0);

    scan_check("main", pack(100, 8191, 300, 4096));
    chk("main.idx_const", 32'(class_idx), 1);
    chk("main.score_const", class_score, 8191);
    scan_check("tie", pack(500, 500, 0, 500));
    chk("tie.idx_const", 32'(class_idx), 0);
    scan_check("zeros", pack(0, 0, 0, 0));
    chk("zeros.score_const", class_score, 0);
    scan_check("last", pack(0, 0, 0, 7));
    chk("last.idx_const", 32'(class_idx), 3);
    scan_check("wide", pack(32'h8000_0000, 32'h7FFF_FFFF, 0, 0));
    chk("wide.score_const", class_score, 32'h8000_0000);

    // Back-to-back: second strobe on the final compare edge
    strobe(pack(1, 2, 3, 4));
    step(); step();
    in_scores = pack(9, 0, 0, 0);
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    in_scores = '1;
    chk("b2b.ov1", 32'(out_valid), 1);
    chk("b2b.idx1", 32'(class_idx), 3);
    chk("b2b.score1", class_score, 4);
    chk("b2b.busy", 32'(busy), 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("b2b.gap_ov", 32'(out_valid), 0);
      chk("b2b.gap_busy", 32'(busy), 1);
    end
    step();
    chk("b2b.ov2", 32'(out_valid), 1);
    chk("b2b.idx2", 32'(class_idx), 0);
    chk("b2b.score2", class_score, 9);
    chk("b2b.busy_end", 32'(busy), 0);
    chk("b2b.drop", 32'(drop), 0);
    step();

    // Randomized vectors, mixing narrow ranges (ties) and full-width values
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++)
        case (n % 3)
          0: v[i] = $urandom_range(0, 3);
          1: v[i] = $urandom_range(0, 16'hFFFF);
          default: v[i] = $urandom();
        endcase
      sc = pack(v[0], v[1], v[2], v[3]);
      scan_check("rand", sc);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end
    chk("rand.drop", 32'(drop), 0);

    // Strobe during scan is dropped and flagged
    strobe(pack(1, 2, 3, 4));
    in_scores = pack(50, 0, 0, 0);
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    chk("drop.set", 32'(drop), 1);
    chk("drop.busy", 32'(busy), 1);
    step(); step();
    chk("drop.ov", 32'(out_valid), 1);
    chk("drop.idx", 32'(class_idx), 3);
    chk("drop.score", class_score, 4);
    for (int i = 0; i < 4; i++) step();
    chk("drop.sticky", 32'(drop), 1);
    chk("drop.idle", 32'(busy), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("drop.clear", 32'(drop), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
